pnb_frame_tx: RTL and testbench

- Transmit-side counterpart of the inter-FPGA SPI receive path. Accepts 41-bit payloads from local logic over a valid/ready handshake and frames each one into an 81-bit frame: header, type, sequence number, payload, reserved bits and a serial CRC-16.
- Shifts the frame MSB-first onto sdo while the remote master clocks sck with cs low.
- Sits beside the SPI receive/protocol-analysis blocks and drives inter_fpga_comms_sdi at the top level.

---
 rtl/pnb_frame_pkg.sv | 66 ++++++
 rtl/crc16_ccitt_serial.sv | 37 +++
 rtl/pnb_frame_tx.sv | 178 +++++++++++++++++
 tb/tb_pnb_frame_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pnb_frame_pkg.sv
// Shared definitions for the inter-FPGA SPI frame: field layout, header, type codes and CRC-16/CCITT.
// Latency: not applicable (package only).
// Backpressure: not applicable (package only).
//
// Frame layout, MSB first (81 bits):
//   [80:73] header  [72:69] type  [68:61] seq  [60:20] payload  [19:16] reserved  [15:0] CRC
// The CRC covers the 65-bit body [80:16].
package pnb_frame_pkg;

   localparam int FRAME_W     = 81;
   localparam int BODY_W      = 65;
   localparam int CRC_W       = 16;
   localparam int PAYLOAD_W   = 41;

   // Bit offsets (MSB of each field) within the full frame.
   localparam int HDR_MSB     = 80;
   localparam int TYPE_MSB    = 72;
   localparam int SEQ_MSB     = 68;
   localparam int PAYLOAD_MSB = 60;
   localparam int RSVD_MSB    = 19;
   localparam int CRC_MSB     = 15;

   localparam logic [7:0]  HDR       = 8'hA5;
   localparam logic [3:0]  TYPE_DATA = 4'h1;
   localparam logic [3:0]  TYPE_IDLE = 4'h0;

   // x^16 + x^12 + x^5 + 1, leading term implied.
   localparam logic [15:0] CRC_POLY  = 16'h1021;
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;

   // The body as it sits in the shift register: hdr lands in the top bits.
   typedef struct packed {
      logic [7:0]  hdr;
      logic [3:0]  typ;
      logic [7:0]  seq;
      logic [40:0] payload;
      logic [3:0]  rsvd;
   } frame_body_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BODY = 2'd1,
      ST_CRC  = 2'd2
   } tx_state_t;

   // One MSB-first step of the serial CRC.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

   // Idle frames carry a zero seq field and zero payload.
   function automatic frame_body_t make_body(input logic        is_data,
                                             input logic [7:0]  seq,
                                             input logic [40:0] payload);
      frame_body_t b;
      b.hdr     = HDR;
      b.typ     = is_data ? TYPE_DATA : TYPE_IDLE;
      b.seq     = is_data ? seq : 8'h00;
      b.payload = is_data ? payload : 41'h0;
      b.rsvd    = 4'h0;
      return b;
   endfunction

endpackage

// File: rtl/crc16_ccitt_serial.sv
// Bit-serial CRC-16/CCITT register, MSB first; shared by the SPI transmit and receive paths.
// Latency: crc reflects din one sck edge after it is presented with en high.
// Backpressure: none; en gates every update.
//
// Ports:
//   sck   rising-edge clock          rstn  async active-low reset (crc -> CRC_INIT)
//   init  reseed to CRC_INIT         en    fold din into the register
//   din   serial data bit            crc   current remainder
// With init and en both high the seed and the first bit are folded in one edge, so a
// frame can start on the same edge that reseeds. Feeding din = crc[15] gives a plain
// zero-fill left shift, which is how the CRC is streamed out.
module crc16_ccitt_serial
   import pnb_frame_pkg::*;
(
   input  logic        sck,
   input  logic        rstn,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] base;

   assign base = init ? CRC_INIT : crc;

   always_ff @(posedge sck or negedge rstn) begin
      if (!rstn) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc16_step(base, din);
      end else if (init) begin
         crc <= CRC_INIT;
      end
   end

endmodule

// File: rtl/pnb_frame_tx.sv
// Frames 41-bit payloads into 81-bit header/type/seq/payload/CRC frames and shifts them out on sdo.
// Latency: 81 sck edges per frame; a payload accepted while idle goes out in the next frame.
// Backpressure: single-entry buffer, pready low while full; it frees when its data frame completes.
//
// Ports:
//   sck         SPI clock from the remote master (all state on rising edge)
//   rstn        async active-low reset
//   cs          active-low chip select; high mid-frame aborts the frame
//   payload     payload word, taken when pvld && pready
//   pvld/pready payload handshake
//   sdo         serial data out, MSB first
//   busy        frame in flight
//   frame_done  pulse after the last CRC bit
//   abort_err   pulse when cs rises mid-frame
//   idle_sent   pulse when a filler frame completes
module pnb_frame_tx
   import pnb_frame_pkg::*;
(
   input  logic        sck,
   input  logic        rstn,
   input  logic        cs,
   input  logic [40:0] payload,
   input  logic        pvld,
   output logic        pready,
   output logic        sdo,
   output logic        busy,
   output logic        frame_done,
   output logic        abort_err,
   output logic        idle_sent
);

   tx_state_t   state, state_nxt;
   logic [6:0]  bitcnt, bitcnt_nxt;
   logic [64:0] shreg, shreg_nxt;
   logic        buf_full;
   logic [40:0] buf_dat;
   logic [7:0]  seq;
   logic        cur_data;       // frame in flight is a data frame

   logic        crc_init, crc_en, crc_din;
   logic [15:0] crc;

   logic        frame_start, frame_end;
   logic        done_nxt, abort_nxt, idle_nxt;

   frame_body_t next_body;

   // Content of the next frame is decided by the buffer state at the start edge, so a
   // payload accepted on that same edge waits for the following frame.
   assign next_body = make_body(buf_full, seq, buf_dat);

   crc16_ccitt_serial u_crc (
      .sck  (sck),
      .rstn (rstn),
      .init (crc_init),
      .en   (crc_en),
      .din  (crc_din),
      .crc  (crc)
   );

   always_comb begin
      state_nxt   = state;
      bitcnt_nxt  = bitcnt;
      shreg_nxt   = shreg;
      crc_init    = 1'b0;
      crc_en      = 1'b0;
      crc_din     = shreg[64];
      frame_start = 1'b0;
      frame_end   = 1'b0;
      done_nxt    = 1'b0;
      abort_nxt   = 1'b0;
      idle_nxt    = 1'b0;

      case (state)
         ST_IDLE: begin
            crc_init = 1'b1;
            if (!cs) begin
               // This edge transmits bit 80, which sdo already shows from the preload.
               state_nxt   = ST_BODY;
               bitcnt_nxt  = 7'd64;
               shreg_nxt   = {next_body[63:0], 1'b0};
               crc_en      = 1'b1;
               crc_din     = next_body[64];
               frame_start = 1'b1;
            end else begin
               shreg_nxt = next_body;
            end
         end

         ST_BODY: begin
            if (cs) begin
               state_nxt  = ST_IDLE;
               bitcnt_nxt = 7'd0;
               shreg_nxt  = next_body;
               crc_init   = 1'b1;
               abort_nxt  = 1'b1;
            end else begin
               crc_en     = 1'b1;
               shreg_nxt  = {shreg[63:0], 1'b0};
               bitcnt_nxt = bitcnt - 7'd1;
               if (bitcnt == 7'd1) begin
                  state_nxt  = ST_CRC;
                  bitcnt_nxt = 7'd15;
               end
            end
         end

         ST_CRC: begin
            // The body register is idle here; keep it preloaded so sdo shows the header
            // MSB as soon as the state machine returns to idle.
            shreg_nxt = next_body;
            if (cs) begin
               state_nxt  = ST_IDLE;
               bitcnt_nxt = 7'd0;
               crc_init   = 1'b1;
               abort_nxt  = 1'b1;
            end else if (bitcnt == 7'd0) begin
               state_nxt = ST_IDLE;
               crc_init  = 1'b1;
               frame_end = 1'b1;
               done_nxt  = 1'b1;
               idle_nxt  = !cur_data;
            end else begin
               crc_en     = 1'b1;
               crc_din    = crc[15];   // cancels feedback: zero-fill shift
               bitcnt_nxt = bitcnt - 7'd1;
            end
         end

         default: begin
            state_nxt  = ST_IDLE;
            bitcnt_nxt = 7'd0;
            shreg_nxt  = next_body;
            crc_init   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge sck or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         bitcnt     <= 7'd0;
         shreg      <= make_body(1'b0, 8'h00, 41'h0);
         buf_full   <= 1'b0;
         buf_dat    <= 41'h0;
         seq        <= 8'h00;
         cur_data   <= 1'b0;
         frame_done <= 1'b0;
         abort_err  <= 1'b0;
         idle_sent  <= 1'b0;
      end else begin
         state      <= state_nxt;
         bitcnt     <= bitcnt_nxt;
         shreg      <= shreg_nxt;
         frame_done <= done_nxt;
         abort_err  <= abort_nxt;
         idle_sent  <= idle_nxt;

         if (frame_start) begin
            cur_data <= buf_full;
         end

         // pready is low while full, so a free and an accept never meet on one edge.
         if (frame_end && cur_data) begin
            buf_full <= 1'b0;
            seq      <= seq + 8'd1;
         end else if (pvld && pready) begin
            buf_full <= 1'b1;
            buf_dat  <= payload;
         end
      end
   end

   assign pready = !buf_full;
   assign busy   = (state != ST_IDLE);
   assign sdo    = (state == ST_CRC) ? crc[15] : shreg[64];

endmodule

// File: tb/tb_pnb_frame_tx.sv
// Self-checking bench for pnb_frame_tx against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pnb_frame_tx;

   logic        sck = 1'b0;
   logic        rstn;
   logic        cs;
   logic [40:0] payload;
   logic        pvld;
   logic        pready;
   logic        sdo;
   logic        busy;
   logic        frame_done;
   logic        abort_err;
   logic        idle_sent;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state: what the transmitter should hold.
   bit          m_full;
   logic [40:0] m_pay;
   logic [7:0]  m_seq;

   pnb_frame_tx dut (
      .sck        (sck),
      .rstn       (rstn),
      .cs         (cs),
      .payload    (payload),
      .pvld       (pvld),
      .pready     (pready),
      .sdo        (sdo),
      .busy       (busy),
      .frame_done (frame_done),
      .abort_err  (abort_err),
      .idle_sent  (idle_sent)
   );

   always #5 sck = ~sck;

   // Expected frame computed as polynomial arithmetic over GF(2):
   // CRC = (body * x^16 + init * x^65) mod P.
   function automatic logic [80:0] ref_frame(input bit is_data, input logic [7:0] s,
                                             input logic [40:0] p);
      logic [64:0] body;
      logic [80:0] m;
      logic [80:0] poly;
      body = {8'hA5, (is_data ? 4'h1 : 4'h0), (is_data ? s : 8'h00),
              (is_data ? p : 41'h0), 4'h0};
      m    = {body, 16'h0000} ^ {16'hFFFF, 65'h0};
      poly = {64'h0, 17'h11021};
      for (int i = 80; i >= 16; i--) begin
         if (m[i]) m = m ^ (poly << (i - 16));
      end
      return {body, m[15:0]};
   endfunction

   function automatic logic [40:0] rand_payload();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[40:0];
   endfunction

   function automatic void model_reset();
      m_full = 1'b0;
      m_pay  = 41'h0;
      m_seq  = 8'h00;
   endfunction

   // Clocks one frame out with cs already low. Called and returns on a negedge.
   // Optionally offers a payload as soon as pready is seen high.
   task automatic run_frame(input bit psh, input logic [40:0] p,
                            output logic [80:0] got, output logic [80:0] exp,
                            output logic dn, output logic idl);
      bit is_data;
      bit pend;
      is_data = m_full;
      exp     = ref_frame(is_data, m_seq, m_pay);
      pend    = psh;
      for (int i = 0; i < 81; i++) begin
         got[80 - i] = sdo;
         if (pvld) begin
            pvld = 1'b0;
         end else if (pend && pready) begin
            pvld    = 1'b1;
            payload = p;
            pend    = 1'b0;
            m_full  = 1'b1;
            m_pay   = p;
         end
         @(negedge sck);
      end
      pvld = 1'b0;
      dn   = frame_done;
      idl  = idle_sent;
      if (is_data) begin
         m_full = 1'b0;
         m_seq  = m_seq + 8'd1;
      end
   endtask

   // Offers one payload while idle (cs high); returns one negedge later.
   task automatic push(input logic [40:0] p, input string tag);
      vectors++;
      if (pready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_pready_before: got %b want 1", tag, pready);
      end
      pvld    = 1'b1;
      payload = p;
      m_full  = 1'b1;
      m_pay   = p;
      @(negedge sck);
      pvld = 1'b0;
      vectors++;
      if (pready !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_pready_after: got %b want 0", tag, pready);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; cs = 1'b1; pvld = 1'b0; payload = 41'h0;
      model_reset();
      @(negedge sck);
      @(negedge sck);
      vectors++;
      if ({pready, busy, frame_done, abort_err, idle_sent, sdo} !== 6'b100001) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy/busy/done/abort/idle/sdo=%b want 100001",
                  {pready, busy, frame_done, abort_err, idle_sent, sdo});
      end
      rstn = 1'b1;
      @(negedge sck);
   endtask

   task automatic test_idle();
      logic [80:0] got, exp;
      logic dn, idl;
      cs = 1'b0;
      run_frame(1'b0, 41'h0, got, exp, dn, idl);
      cs = 1'b1;
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL idle_frame: got %h want %h", got, exp);
      end
      vectors++;
      if (got[80:16] !== {8'hA5, 57'h0}) begin
         miscompares++;
         $display("FAIL idle_body: got %h want %h", got[80:16], {8'hA5, 57'h0});
      end
      vectors++;
      if ({dn, idl} !== 2'b11) begin
         miscompares++;
         $display("FAIL idle_pulses: got done/idle=%b want 11", {dn, idl});
      end
      @(negedge sck);
      vectors++;
      if ({frame_done, idle_sent, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL idle_pulse_width: got done/idle/busy=%b want 000",
                  {frame_done, idle_sent, busy});
      end
   endtask

   task automatic test_single_payload();
      logic [80:0] got, exp;
      logic dn, idl;
      push(41'h1_2345_6789A, "single");
      cs = 1'b0;
      run_frame(1'b0, 41'h0, got, exp, dn, idl);
      cs = 1'b1;
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL single_frame: got %h want %h", got, exp);
      end
      vectors++;
      if (got[72:20] !== {4'h1, 8'h00, 41'h1_2345_6789A}) begin
         miscompares++;
         $display("FAIL single_fields: got %h want %h", got[72:20],
                  {4'h1, 8'h00, 41'h1_2345_6789A});
      end
      vectors++;
      if ({dn, idl, pready} !== 3'b101) begin
         miscompares++;
         $display("FAIL single_done: got done/idle/pready=%b want 101", {dn, idl, pready});
      end
      push(rand_payload(), "single2");
      cs = 1'b0;
      run_frame(1'b0, 41'h0, got, exp, dn, idl);
      cs = 1'b1;
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL second_frame: got %h want %h", got, exp);
      end
      vectors++;
      if (got[68:61] !== 8'h01) begin
         miscompares++;
         $display("FAIL second_seq: got %h want 01", got[68:61]);
      end
   endtask

   // cs stays low across three frames: the payload offered when the buffer frees is
   // taken on the next frame's start edge, so that frame is filler and the one after
   // carries it.
   task automatic test_back_to_back();
      logic [80:0] got, exp;
      logic dn, idl;
      logic [40:0] pb;
      pb = rand_payload();
      push(rand_payload(), "b2b");
      cs = 1'b0;
      run_frame(1'b0, 41'h0, got, exp, dn, idl);
      vectors++;
      if (got !== exp || dn !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_frame0: got %h done %b want %h done 1", got, dn, exp);
      end
      run_frame(1'b1, pb, got, exp, dn, idl);
      vectors++;
      if (got !== exp || idl !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_frame1: got %h idle %b want %h idle 1", got, idl, exp);
      end
      run_frame(1'b0, 41'h0, got, exp, dn, idl);
      cs = 1'b1;
      vectors++;
      if (got !== exp || idl !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_frame2: got %h idle %b want %h idle 0", got, idl, exp);
      end
      vectors++;
      if (got[60:20] !== pb) begin
         miscompares++;
         $display("FAIL b2b_payload: got %h want %h", got[60:20], pb);
      end
      @(negedge sck);
   endtask

   task automatic test_reset_mid_crc();
      logic [80:0] got, exp;
      logic dn, idl;
      push(rand_payload(), "rst");
      cs = 1'b0;
      for (int i = 0; i < 70; i++) @(negedge sck);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_busy_before: got %b want 1", busy);
      end
      rstn = 1'b0;
      cs   = 1'b1;
      model_reset();
      #1;
      vectors++;
      if ({pready, busy, sdo, frame_done} !== 4'b1010) begin
         miscompares++;
         $display("FAIL rst_mid_crc: got rdy/busy/sdo/done=%b want 1010",
                  {pready, busy, sdo, frame_done});
      end
      @(negedge sck);
      rstn = 1'b1;
      @(negedge sck);
      push(rand_payload(), "rst_after");
      cs = 1'b0;
      run_frame(1'b0, 41'h0, got, exp, dn, idl);
      cs = 1'b1;
      vectors++;
      if (got !== exp || got[68:61] !== 8'h00) begin
         miscompares++;
         $display("FAIL rst_seq_cleared: got %h want %h", got, exp);
      end
   endtask

   task automatic test_abort();
      logic [80:0] part, got, exp;
      logic dn, idl;
      push(rand_payload(), "abort");
      exp = ref_frame(1'b1, m_seq, m_pay);
      part = '0;
      cs = 1'b0;
      for (int i = 0; i < 40; i++) begin
         part[80 - i] = sdo;
         @(negedge sck);
      end
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_busy: got %b want 1", busy);
      end
      cs = 1'b1;
      @(negedge sck);
      vectors++;
      if ({abort_err, busy, pready, frame_done, sdo} !== 5'b10001) begin
         miscompares++;
         $display("FAIL abort_pulse: got abort/busy/rdy/done/sdo=%b want 10001",
                  {abort_err, busy, pready, frame_done, sdo});
      end
      vectors++;
      if (part[80:41] !== exp[80:41]) begin
         miscompares++;
         $display("FAIL abort_partial: got %h want %h", part[80:41], exp[80:41]);
      end
      @(negedge sck);
      vectors++;
      if (abort_err !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_width: got %b want 0", abort_err);
      end
      cs = 1'b0;
      run_frame(1'b0, 41'h0, got, exp, dn, idl);
      cs = 1'b1;
      vectors++;
      if (got !== exp || got[80:41] !== part[80:41] || dn !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_retry: got %h done %b want %h done 1", got, dn, exp);
      end
   endtask

   task automatic test_seq_wrap();
      logic [80:0] got, exp;
      logic dn, idl;
      rstn = 1'b0;
      cs   = 1'b1;
      model_reset();
      @(negedge sck);
      rstn = 1'b1;
      @(negedge sck);
      for (int k = 1; k <= 257; k++) begin
         push(rand_payload(), "wrap");
         cs = 1'b0;
         run_frame(1'b0, 41'h0, got, exp, dn, idl);
         cs = 1'b1;
         vectors++;
         if (got !== exp || dn !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_frame%0d: got %h want %h", k, got, exp);
         end
         if (k == 256) begin
            vectors++;
            if (got[68:61] !== 8'hFF) begin
               miscompares++;
               $display("FAIL wrap_seq256: got %h want ff", got[68:61]);
            end
         end
         if (k == 257) begin
            vectors++;
            if (got[68:61] !== 8'h00) begin
               miscompares++;
               $display("FAIL wrap_seq257: got %h want 00", got[68:61]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_payload();
      test_back_to_back();
      test_reset_mid_crc();
      test_abort();
      test_seq_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
